instr_fetch_sequencer: RTL and testbench
========================================

Name: instr_fetch_sequencer

Overview:
- Upstream control stage for the 16-bit instruction register (IR) and program counter (PC) Register instances.
- Fetches one 16-bit instruction as two bytes from byte-wide memory over a req/ack handshake. Byte order is little-endian: low byte at A, high byte at A+1.
- Drives E/FunSel/I of the IR to assemble the word, and E/FunSel of the PC to step it.
- Presents the completed instruction to decode with a valid/ready handshake.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- MAX_WAIT, 15, cycles in a request state without MemAck before fault. Used only with FETCH_TIMEOUT_EN.

Ports:
- Clock  in  1  single system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Enable  in  1  run request; sampled only in IDLE and on VALID exit.
- PC  in  ADDR_W  current PC register value.
- MemReq  out  1  memory read request.
- MemAddr  out  ADDR_W  byte address for current request.
- MemAck  in  1  memory returns MemData this cycle.
- MemData  in  8  read byte.
- PC_E  out  1  PC register enable.
- PC_FunSel  out  3  PC function select.
- IR_E  out  1  IR register enable.
- IR_FunSel  out  3  IR function select.
- IR_I  out  16  IR data input.
- InstrValid  out  1  IR holds complete instruction.
- InstrReady  in  1  decode consumes instruction.
- Fault  out  1  sticky memory-timeout flag.

Behaviour:
- Outputs: all registered, Moore-style.
- Reset (Reset=0, async) values:
  - State = IDLE.
  - All outputs 0: MemAddr=0, IR_I=0, PC_FunSel=000, IR_FunSel=000.
  - Byte latch = 0; wait counter = 0.
- State sequence: IDLE, REQ_LO, WR_LO, REQ_HI, WR_HI, VALID, FAULT.
- IDLE:
  - Enable=1 -> REQ_LO, and MemAddr<=PC captured on that edge.
- REQ_LO:
  - MemReq=1.
  - MemAck=1 -> latch MemData, go to WR_LO. MemReq drops the following cycle.
- WR_LO (exactly 1 cycle):
  - IR_E=1, IR_FunSel=100, IR_I={8'h00,latched}; this clears the IR high byte and writes the low byte.
  - PC_E=1, PC_FunSel=001 (increment).
  - MemAddr<=MemAddr+1 (internal, wraps at 2^ADDR_W).
  - Next state REQ_HI.
- REQ_HI:
  - MemReq=1.
  - MemAck=1 -> latch, go to WR_HI.
- WR_HI (1 cycle):
  - IR_E=1, IR_FunSel=110, IR_I={8'h00,latched}; writes the IR high byte only.
  - PC_E=1, PC_FunSel=001.
  - Next state VALID.
- VALID:
  - InstrValid=1 held until InstrReady=1.
  - On handshake with Enable=1 -> REQ_LO, MemAddr<=PC.
  - On handshake with Enable=0 -> IDLE.
- PC_E and IR_E are 0 in every state other than WR_LO/WR_HI.
- Latency, best case (MemAck in the first REQ cycle): Enable sampled to InstrValid = 5 cycles.
- Boundary conditions:
  - MemAck outside REQ states is ignored; MemData is captured only in REQ states.
  - Enable falling mid-fetch has no effect; the fetch completes to VALID.
  - InstrReady outside VALID is ignored.
  - MemAddr wraps 0xFFFF -> 0x0000 for the high byte.
  - Reset mid-fetch aborts immediately; partial IR content is not flagged valid.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro defined:
  - Wait counter clears on entry to REQ_LO/REQ_HI and increments each REQ cycle without MemAck.
  - When it reaches MAX_WAIT -> FAULT: MemReq=0, Fault=1, all enables 0.
  - FAULT is left only by Reset.
  - MemAck in the same cycle the counter reaches MAX_WAIT wins, i.e. no fault.
- Without the macro: no counter, REQ states wait indefinitely, Fault tied to 0, FAULT state unreachable.

Decomposition:
- Shared package fetch_pkg:
  - State encoding.
  - Register FunSel constants: FS_DEC=000, FS_INC=001, FS_LOAD=010, FS_CLR=011, FS_WRLO_CLR=100, FS_WRLO=101, FS_WRHI=110, FS_SEXT=111.
  - Default widths.
- One sub-module: fetch_wait_timer (clearable saturating counter with terminal flag), instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Zero-wait fetch:
  - Stimulus: PC=0x0040, Enable=1, mem[0x40]=0x34, mem[0x41]=0x12, MemAck the cycle after MemReq.
  - Response: WR_LO drives IR_I=0x0034/100 and WR_HI drives IR_I=0x0012/110; two PC_E pulses with FunSel 001; InstrValid 5 cycles after Enable.
- Back-pressure:
  - Stimulus: InstrReady held 0 for 10 cycles.
  - Response: InstrValid stays 1, MemReq=0, no IR_E/PC_E pulses; on InstrReady=1 with Enable=1, next MemAddr=new PC.
- Wait states:
  - Stimulus: MemAck delayed 3 cycles per byte.
  - Response: MemReq held 4 cycles per byte, MemAddr stable, instruction correct, Fault=0.
- Wrap:
  - Stimulus: PC=0xFFFF.
  - Response: low byte requested at 0xFFFF, high byte at 0x0000.
- Timeout (FETCH_TIMEOUT_EN):
  - Stimulus: MemAck never asserted.
  - Response: Fault=1 after 15 REQ_LO cycles, MemReq=0, persists until Reset=0.
- Reset mid-fetch:
  - Stimulus: Reset=0 during REQ_HI.
  - Response: all outputs 0 immediately (asynchronously); after release, state IDLE awaiting Enable.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// register function-select codes and default widths.
package fetch_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int MAX_WAIT_DEF = 15;
  localparam int BYTE_W       = 8;
  localparam int IR_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_LO = 3'd1,
    ST_WR_LO  = 3'd2,
    ST_REQ_HI = 3'd3,
    ST_WR_HI  = 3'd4,
    ST_VALID  = 3'd5,
    ST_FAULT  = 3'd6
  } fetch_state_t;

  // Function-select codes understood by the PC/IR Register instances
  localparam logic [2:0] FS_DEC      = 3'b000;
  localparam logic [2:0] FS_INC      = 3'b001;
  localparam logic [2:0] FS_LOAD     = 3'b010;
  localparam logic [2:0] FS_CLR      = 3'b011;
  localparam logic [2:0] FS_WRLO_CLR = 3'b100;
  localparam logic [2:0] FS_WRLO     = 3'b101;
  localparam logic [2:0] FS_WRHI     = 3'b110;
  localparam logic [2:0] FS_SEXT     = 3'b111;

  function automatic logic [IR_W-1:0] zext_byte(input logic [BYTE_W-1:0] b);
    return {{(IR_W-BYTE_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Clearable saturating wait counter; expire flags the cycle in which an
// increment would bring the count to LIMIT.
module fetch_wait_timer #(
  parameter int LIMIT = 15,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign expire = inc && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetches a little-endian 16-bit instruction as two bytes and steers the IR/PC
// registers. Optional request timeout is enabled with FETCH_TIMEOUT_EN.
module instr_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [BYTE_W-1:0] mem_data,
  output logic              pc_e,
  output logic [2:0]        pc_funsel,
  output logic              ir_e,
  output logic [2:0]        ir_funsel,
  output logic [IR_W-1:0]   ir_i,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fault
);

  fetch_state_t      state;
  logic [BYTE_W-1:0] byte_latch;
  logic              timeout;

  // The latch only changes on an accepted byte, so it already is the IR data word
  assign ir_i = zext_byte(byte_latch);

`ifdef FETCH_TIMEOUT_EN
  logic in_req;
  logic fault_reg;

  assign in_req = (state == ST_REQ_LO) || (state == ST_REQ_HI);

  fetch_wait_timer #(
    .LIMIT (MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!in_req),
    .inc    (in_req && !mem_ack),
    .expire (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_reg <= 1'b0;
    end else if (timeout) begin
      fault_reg <= 1'b1;
    end
  end

  assign fault = fault_reg;
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      byte_latch  <= '0;
      pc_e        <= 1'b0;
      pc_funsel   <= FS_DEC;
      ir_e        <= 1'b0;
      ir_funsel   <= FS_DEC;
      instr_valid <= 1'b0;
    end else begin
      mem_req     <= 1'b0;
      pc_e        <= 1'b0;
      pc_funsel   <= FS_DEC;
      ir_e        <= 1'b0;
      ir_funsel   <= FS_DEC;
      instr_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state    <= ST_REQ_LO;
            mem_addr <= pc;
            mem_req  <= 1'b1;
          end
        end
        ST_REQ_LO: begin
          // An ack arriving together with the timeout still wins
          if (mem_ack) begin
            state      <= ST_WR_LO;
            byte_latch <= mem_data;
            ir_e       <= 1'b1;
            ir_funsel  <= FS_WRLO_CLR;
            pc_e       <= 1'b1;
            pc_funsel  <= FS_INC;
          end else if (timeout) begin
            state <= ST_FAULT;
          end else begin
            mem_req <= 1'b1;
          end
        end
        ST_WR_LO: begin
          state    <= ST_REQ_HI;
          mem_addr <= mem_addr + 1'b1;
          mem_req  <= 1'b1;
        end
        ST_REQ_HI: begin
          if (mem_ack) begin
            state      <= ST_WR_HI;
            byte_latch <= mem_data;
            ir_e       <= 1'b1;
            ir_funsel  <= FS_WRHI;
            pc_e       <= 1'b1;
            pc_funsel  <= FS_INC;
          end else if (timeout) begin
            state <= ST_FAULT;
          end else begin
            mem_req <= 1'b1;
          end
        end
        ST_WR_HI: begin
          state       <= ST_VALID;
          instr_valid <= 1'b1;
        end
        ST_VALID: begin
          if (instr_ready) begin
            if (enable) begin
              state    <= ST_REQ_LO;
              mem_addr <= pc;
              mem_req  <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            instr_valid <= 1'b1;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer: byte-wide memory responder,
// IR register model and an expected-address/instruction scoreboard.
module tb_instr_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        pc_e;
  logic [2:0]  pc_funsel;
  logic        ir_e;
  logic [2:0]  ir_funsel;
  logic [15:0] ir_i;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        fault;

  typedef struct {
    logic [15:0] addr;
    bit          hi;
  } req_t;

  req_t        addr_q[$];
  logic [15:0] instr_q[$];
  req_t        cur_req;
  logic [15:0] exp_instr;
  int          total = 0;
  int          passed = 0;
  int          ack_delay = 0;
  bit          stray_ack = 1'b0;
  int          req_cnt = 0;
  bit          wr_pending = 1'b0;
  logic [7:0]  wr_byte = 8'h00;
  bit          wr_hi = 1'b0;
  int          pc_pulses = 0;
  int          n_instr = 0;
  logic [15:0] ir_model = 16'h0000;
  int          lat;

  instr_fetch_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pc          (pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .pc_e        (pc_e),
    .pc_funsel   (pc_funsel),
    .ir_e        (ir_e),
    .ir_funsel   (ir_funsel),
    .ir_i        (ir_i),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memval(input logic [15:0] a);
    if (a == 16'h0040) return 8'h34;
    if (a == 16'h0041) return 8'h12;
    return a[7:0] + (a[15:8] * 8'd3) + 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_fetch(input logic [15:0] p);
    addr_q.push_back('{p, 1'b0});
    addr_q.push_back('{p + 16'd1, 1'b1});
    instr_q.push_back({memval(p + 16'd1), memval(p)});
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 1;
    while (!instr_valid && cycles < 200) begin
      step();
      cycles++;
    end
    chk("valid_seen", 32'(instr_valid), 32'd1);
  endtask

  task automatic run_fetch(input logic [15:0] p, input int dly, input bit check_lat);
    int l;
    ack_delay = dly;
    expect_fetch(p);
    pc = p;
    enable = 1'b1;
    instr_ready = 1'b1;
    step();
    enable = 1'b0;
    wait_valid(l);
    if (check_lat) chk("latency", 32'(l), 32'd5);
    chk("fault_low", 32'(fault), 32'd0);
    step();
    chk("valid_drop", 32'(instr_valid), 32'd0);
  endtask

  // External IR register: function select semantics of the Register instance
  always @(posedge clk) begin
    if (ir_e) begin
      if (ir_funsel == FS_WRLO_CLR) ir_model <= {8'h00, ir_i[7:0]};
      else if (ir_funsel == FS_WRHI) ir_model[15:8] <= ir_i[7:0];
    end
  end

  // Memory responder, write-strobe checker and instruction scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      req_cnt = 0;
      wr_pending = 1'b0;
      pc_pulses = 0;
    end else begin
      if (wr_pending) begin
        chk("wr_ir_e", 32'(ir_e), 32'd1);
        chk("wr_ir_funsel", 32'(ir_funsel), 32'(wr_hi ? FS_WRHI : FS_WRLO_CLR));
        chk("wr_ir_i", 32'(ir_i), 32'({8'h00, wr_byte}));
        chk("wr_pc_e", 32'(pc_e), 32'd1);
        chk("wr_pc_funsel", 32'(pc_funsel), 32'(FS_INC));
        pc_pulses++;
        wr_pending = 1'b0;
      end else begin
        chk("no_strobe", 32'({ir_e, pc_e}), 32'd0);
      end
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          if (addr_q.size() == 0) begin
            chk("unexpected_req", 32'(addr_q.size()), 32'd1);
          end else begin
            cur_req = addr_q.pop_front();
            chk("req_addr", 32'(mem_addr), 32'(cur_req.addr));
          end
        end else begin
          chk("addr_stable", 32'(mem_addr), 32'(cur_req.addr));
        end
        if (req_cnt > ack_delay) begin
          mem_ack = 1'b1;
          mem_data = memval(mem_addr);
          wr_pending = 1'b1;
          wr_byte = mem_data;
          wr_hi = cur_req.hi;
        end else begin
          mem_ack = 1'b0;
          mem_data = 8'h00;
        end
      end else begin
        req_cnt = 0;
        mem_ack = stray_ack;
        mem_data = stray_ack ? 8'hEE : 8'h00;
      end
      if (instr_valid && instr_ready) begin
        if (instr_q.size() == 0) begin
          chk("unexpected_valid", 32'(instr_q.size()), 32'd1);
        end else begin
          exp_instr = instr_q.pop_front();
          chk("instr", 32'(ir_model), 32'(exp_instr));
          chk("pc_pulses", 32'(pc_pulses), 32'd2);
          $display("instr %0d: ir=%04h expected=%04h pc_pulses=%0d", n_instr, ir_model, exp_instr, pc_pulses);
          n_instr++;
        end
        pc_pulses = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_ir_i", 32'(ir_i), 32'd0);
    chk("rst_funsels", 32'({pc_funsel, ir_funsel}), 32'd0);
    chk("rst_strobes", 32'({pc_e, ir_e, instr_valid, fault}), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_no_req", 32'(mem_req), 32'd0);

    // Zero-wait fetch, best-case latency, Enable dropped mid-fetch
    run_fetch(16'h0040, 0, 1'b1);
    chk("ir_1234", 32'(ir_model), 32'h1234);

    // Back-pressure, then VALID -> REQ_LO with a new PC
    ack_delay = 0;
    expect_fetch(16'h0080);
    pc = 16'h0080;
    enable = 1'b1;
    instr_ready = 1'b0;
    step();
    enable = 1'b0;
    wait_valid(lat);
    repeat (10) begin
      step();
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_req", 32'(mem_req), 32'd0);
      chk("bp_strobes", 32'({ir_e, pc_e}), 32'd0);
    end
    pc = 16'h0300;
    expect_fetch(16'h0300);
    enable = 1'b1;
    instr_ready = 1'b1;
    step();
    chk("bp_next_addr", 32'(mem_addr), 32'h0300);
    chk("bp_next_req", 32'(mem_req), 32'd1);
    enable = 1'b0;
    wait_valid(lat);
    step();

    // Wait states, address wrap, stray acks outside request states
    run_fetch(16'h1234, 3, 1'b0);
    run_fetch(16'hFFFF, 1, 1'b0);
    stray_ack = 1'b1;
    run_fetch(16'h0A0B, 2, 1'b0);
    stray_ack = 1'b0;

`ifndef FETCH_TIMEOUT_EN
    run_fetch(16'h0500, 40, 1'b0);
`endif

    // Reset during REQ_HI aborts the fetch
    ack_delay = 5;
    expect_fetch(16'h0100);
    pc = 16'h0100;
    enable = 1'b1;
    step();
    enable = 1'b0;
    lat = 0;
    while (!(mem_req && mem_addr == 16'h0101) && lat < 100) begin
      step();
      lat++;
    end
    chk("reached_req_hi", 32'(mem_addr), 32'h0101);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_req_addr", 32'({mem_req, mem_addr}), 32'd0);
    chk("arst_ir", 32'({ir_e, ir_funsel, ir_i}), 32'd0);
    chk("arst_pc", 32'({pc_e, pc_funsel}), 32'd0);
    chk("arst_valid_fault", 32'({instr_valid, fault}), 32'd0);
    addr_q.delete();
    instr_q.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("post_rst_idle", 32'({mem_req, instr_valid}), 32'd0);
    end
    run_fetch(16'h2000, 0, 1'b1);

`ifdef FETCH_TIMEOUT_EN
    // No ack at all: fault after MAX_WAIT request cycles, held until reset
    ack_delay = 1000000;
    addr_q.push_back('{16'h0200, 1'b0});
    pc = 16'h0200;
    enable = 1'b1;
    step();
    enable = 1'b0;
    lat = 0;
    while (!fault && lat < 100) begin
      step();
      lat++;
    end
    chk("timeout_cycles", 32'(lat), 32'd15);
    repeat (20) begin
      step();
      chk("fault_sticky", 32'({fault, mem_req, ir_e, pc_e, instr_valid}), 32'b10000);
    end
    rst_n = 1'b0;
    #1;
    chk("fault_cleared", 32'(fault), 32'd0);
    addr_q.delete();
    step();
    rst_n = 1'b1;
    step();
`endif

    chk("queues_drained", 32'(addr_q.size() + instr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
